// File: rtl/axis_echo_pkg.sv
// Shared types for axis_echo_responder: FSM state and the buffered flit.
// Flit fields are sized for the widest supported stream; unused bits stay zero.
package axis_echo_pkg;

  localparam int FLIT_DATA_MAX = 64;
  localparam int FLIT_ID_MAX = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef struct packed {
    logic [FLIT_DATA_MAX-1:0] tdata;
    logic                     tlast;
    logic [FLIT_ID_MAX-1:0]   tid;
  } flit_t;

  localparam int FLIT_W = $bits(flit_t);

endpackage

// File: rtl/axis_echo_fifo.sv
// Single-clock circular flit FIFO with full/empty flags.
// A push into a full FIFO is taken when a pop happens in the same cycle.
module axis_echo_fifo
  import axis_echo_pkg::*;
#(
  parameter int WIDTH = FLIT_W,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/axis_echo_responder.sv
// AXI-Stream echo endpoint: buffers whole packets and returns them to their source.
// Define AXIS_ECHO_TIMESTAMP_EN to stamp ticks into the first egress flit.
module axis_echo_responder
  import axis_echo_pkg::*;
#(
  parameter int TDATA_WIDTH = 32,
  parameter int TDEST_WIDTH = 2,
  parameter int TID_WIDTH   = 2,
  parameter int TID         = 0,
  parameter int FIFO_DEPTH  = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TDATA_WIDTH/2-1:0] ticks,
  input  logic                     axis_in_tvalid,
  output logic                     axis_in_tready,
  input  logic [TDATA_WIDTH-1:0]   axis_in_tdata,
  input  logic                     axis_in_tlast,
  input  logic [TID_WIDTH-1:0]     axis_in_tid,
  input  logic [TDEST_WIDTH-1:0]   axis_in_tdest,
  output logic                     axis_out_tvalid,
  input  logic                     axis_out_tready,
  output logic [TDATA_WIDTH-1:0]   axis_out_tdata,
  output logic                     axis_out_tlast,
  output logic [TID_WIDTH-1:0]     axis_out_tid,
  output logic [TDEST_WIDTH-1:0]   axis_out_tdest,
  output logic [(2**TDEST_WIDTH)-1:0][COUNT_WIDTH-1:0] resp_packets,
  output logic                     oversize
);

  localparam int PW = $clog2(FIFO_DEPTH) + 1;

  state_t state;
  state_t state_nx;
  flit_t  wr_flit;
  flit_t  rd_flit;

  logic          full;
  logic          empty;
  logic          in_hs;
  logic          out_hs;
  logic          pop_last;
  logic          ready_q;
  logic          inc_q;
  logic          fallback;
  logic          start;
  logic [PW-1:0] pkt_cnt;
  logic [TDEST_WIDTH-1:0] dest_q;
  logic          unused_ok;

  assign axis_in_tready = ready_q && !full;
  assign in_hs    = axis_in_tvalid && axis_in_tready;
  assign out_hs   = axis_out_tvalid && axis_out_tready;
  assign pop_last = out_hs && rd_flit.tlast;

  always_comb begin
    wr_flit = '0;
    wr_flit.tdata[TDATA_WIDTH-1:0] = axis_in_tdata;
    wr_flit.tlast = axis_in_tlast;
    wr_flit.tid[TID_WIDTH-1:0] = axis_in_tid;
  end

  axis_echo_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_hs),
    .wr_data (wr_flit),
    .pop     (out_hs),
    .rd_data (rd_flit),
    .full    (full),
    .empty   (empty)
  );

  // Packet completion is counted one cycle after the tlast push,
  // which gives the two-edge minimum request-to-response latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      inc_q   <= 1'b0;
      pkt_cnt <= '0;
    end else begin
      ready_q <= 1'b1;
      inc_q   <= in_hs && axis_in_tlast;
      case ({inc_q, pop_last})
        2'b10:   pkt_cnt <= pkt_cnt + PW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - PW'(1);
        default: ;
      endcase
    end
  end

  // Full with no complete packet (and none about to be counted) means
  // the packet cannot fit: start forwarding it anyway.
  assign fallback = full && (pkt_cnt == '0) && !inc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pkt_cnt != '0 || fallback) state_nx = SEND;
      SEND:    if (pop_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    start = 1'b0;
    axis_out_tvalid = 1'b0;
    case (state)
      IDLE:    start = (state_nx == SEND);
      SEND:    axis_out_tvalid = !empty;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_q       <= '0;
      oversize     <= 1'b0;
      resp_packets <= '0;
    end else begin
      if (start) dest_q <= TDEST_WIDTH'(rd_flit.tid[TID_WIDTH-1:0]);
      if (start && fallback) oversize <= 1'b1;
      if (pop_last && resp_packets[dest_q] != '1)
        resp_packets[dest_q] <= resp_packets[dest_q] + COUNT_WIDTH'(1);
    end
  end

  assign axis_out_tdest = dest_q;
  assign axis_out_tid   = TID_WIDTH'(TID);
  assign axis_out_tlast = rd_flit.tlast;

`ifdef AXIS_ECHO_TIMESTAMP_EN
  localparam int HALF = TDATA_WIDTH / 2;

  logic            first_q;
  logic            ts_taken;
  logic [HALF-1:0] ts_q;
  logic [HALF-1:0] stamp;

  // The stamp is frozen after the first valid cycle so the payload
  // stays stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q  <= 1'b1;
      ts_taken <= 1'b0;
      ts_q     <= '0;
    end else if (out_hs) begin
      first_q  <= rd_flit.tlast;
      ts_taken <= 1'b0;
    end else if (axis_out_tvalid && first_q && !ts_taken) begin
      ts_taken <= 1'b1;
      ts_q     <= ticks;
    end
  end

  assign stamp = ts_taken ? ts_q : ticks;
  assign axis_out_tdata = first_q ?
    {stamp, rd_flit.tdata[HALF-1:0]} :
    rd_flit.tdata[TDATA_WIDTH-1:0];
  assign unused_ok = ^{rd_flit, axis_in_tdest};
`else
  assign axis_out_tdata = rd_flit.tdata[TDATA_WIDTH-1:0];
  assign unused_ok = ^{rd_flit, axis_in_tdest, ticks};
`endif

endmodule

// File: doc/axis_echo_responder.md
AXIS_ECHO_RESPONDER -- requirements
Module: axis_echo_responder

Interface
REQ-001 SHALL take parameter TDATA_WIDTH, default 32, flit data width.
REQ-002 SHALL take parameter TDEST_WIDTH, default 2, destination field width.
REQ-003 SHALL take parameter TID_WIDTH, default 2, source-ID field width.
REQ-004 SHALL take parameter TID, default 0, this endpoint's ID, driven on axis_out_tid.
REQ-005 SHALL take parameter FIFO_DEPTH, default 16, flit buffer depth, power of two, at least 2.
REQ-006 SHALL take parameter COUNT_WIDTH, default 16, width of each response counter.
REQ-007 SHALL have the following ports, clock and reset first:
- clk, input, 1: sole clock.
- rst, input, 1: reset, asynchronous, active-high.
- ticks, input, TDATA_WIDTH/2: free-running timestamp.
- axis_in_tvalid / tready / tdata / tlast / tid / tdest: input, output, input, input, input, input; widths 1 / 1 / TDATA_WIDTH / 1 / TID_WIDTH / TDEST_WIDTH; request stream from the NoC.
- axis_out_tvalid / tready / tdata / tlast / tid / tdest: output, input, output, output, output, output; widths as axis_in; response stream to the NoC.
- resp_packets, output, [2**TDEST_WIDTH] x COUNT_WIDTH: responses sent, one counter per destination.
- oversize, output, 1: sticky flag, a packet exceeded FIFO_DEPTH.

Function
REQ-008 SHALL accept an input flit on a cycle where axis_in_tvalid and axis_in_tready are both high at the rising edge.
REQ-009 SHALL drive axis_in_tready = FIFO not full.
REQ-010 SHALL store tdata, tlast and tid per flit in a FIFO_DEPTH-entry circular FIFO; pointers wrap modulo FIFO_DEPTH.
REQ-011 SHALL keep a count of complete packets, pkt_cnt: +1 on acceptance of a tlast flit, -1 on egress of a tlast flit; simultaneous increment and decrement leave it unchanged.
REQ-012 SHALL implement FSM IDLE -> SEND -> IDLE.
- IDLE -> SEND when pkt_cnt > 0, or when the FIFO is full with pkt_cnt = 0 (cut-through fallback, which sets oversize).
- SEND -> IDLE on the egress handshake of a tlast flit.
REQ-013 SHALL hold axis_out_tvalid high in SEND while the FIFO is non-empty, and low otherwise.
REQ-014 SHALL drive outputs as follows:
- axis_out_tdest = tid of the packet's first flit, latched at packet start.
- axis_out_tid = TID.
- axis_out_tdata = stored tdata.
- axis_out_tlast = stored tlast.
REQ-015 SHALL keep all axis_out payload signals stable while tvalid is high and tready is low.
REQ-016 SHALL assert axis_out_tvalid at the earliest 2 clk edges after the edge accepting the tlast flit, when the FIFO was empty and the FSM was IDLE.
REQ-017 SHALL sustain one flit per cycle in both directions at the same time; a full FIFO with a simultaneous pop SHALL accept the push.
REQ-018 SHALL increment resp_packets[axis_out_tdest] on each tlast egress, saturating at all-ones.
REQ-019 SHALL never reorder flits or interleave packets.

Reset
REQ-020 SHALL, on assertion of rst at any time including mid-packet:
- empty the FIFO;
- clear pkt_cnt;
- set the FSM to IDLE;
- drive axis_in_tready = 0 and axis_out_tvalid = 0;
- clear resp_packets and oversize.
REQ-021 SHALL drive axis_in_tready = 1 from the first edge after rst deasserts.
REQ-022 SHALL discard any partial packet when reset is applied.

Configuration
REQ-023 SHALL, with macro AXIS_ECHO_TIMESTAMP_EN defined, replace the upper TDATA_WIDTH/2 bits of each packet's first egress flit with the ticks value sampled when that flit first becomes valid, held stable until the handshake.
REQ-024 SHALL, without the macro, pass tdata unmodified and leave ticks unused.

Structure
REQ-025 SHALL place the FSM state enum (IDLE, SEND) and the flit struct (tdata, tlast, tid) in the shared package axis_echo_pkg.
REQ-026 SHALL implement the FIFO as the sub-module axis_echo_fifo: single clock, push and pop ports, full and empty flags, simultaneous push and pop allowed.

Verification
REQ-027 SHALL cover single-flit packet: tid=2, tdata=0xDEADBEEF, tlast=1 -> axis_out tdest=2, tid=TID, data 0xDEADBEEF, tvalid 2 edges later, resp_packets[2]=1.
REQ-028 SHALL cover back-to-back 4-flit packets from tid 1 and tid 3 with tready tied high -> two packets in order with tdest 1 then 3, no gaps after the first flit, counters [1]=1 and [3]=1.
REQ-029 SHALL cover backpressure: tready=0 for 20 cycles with FIFO_DEPTH=16 -> axis_in_tready falls after 16 flits accepted, payload stable, no loss after release.
REQ-030 SHALL cover a 20-flit packet with FIFO_DEPTH=16 -> cut-through egress starts when full, oversize=1, all 20 flits delivered intact.
REQ-031 SHALL cover rst asserted after flit 2 of 4 -> outputs zero immediately, counters 0, a following 1-flit packet echoes correctly.
REQ-032 SHALL cover AXIS_ECHO_TIMESTAMP_EN defined, ticks=0x1234 at first-valid -> first flit data[31:16]=0x1234, lower half unchanged.
